fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 16, instruction word width; fields: opcode [15:12], operand1 [11:6], operand2 [5:0].
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, instruction memory address width.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, at least 2).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, declared first as listed below.
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 i_flush  input  1  discards all buffered or in-flight instructions and redirects fetch.
REQ-008 i_flush_addr  input  ADDR_WIDTH  new PC, sampled when i_flush=1.
REQ-009 o_mem_addr  output  ADDR_WIDTH  instruction memory read address.
REQ-010 o_mem_rd  output  1  read strobe; memory returns i_mem_data exactly one cycle later.
REQ-011 i_mem_data  input  INST_WIDTH  read data, valid the cycle after o_mem_rd.
REQ-012 o_opcode / o_operand1 / o_operand2  output  4 / 6 / 6  fields of the buffer head.
REQ-013 o_inst_pc  output  ADDR_WIDTH  address of the buffer head.
REQ-014 o_inst_ready  output  1  buffer head valid.
REQ-015 i_inst_ack  input  1  one-cycle pulse from the consumer: head consumed.
REQ-016 o_halted  output  1  fetch stopped on HLT.

Function
REQ-017 SHALL drive o_inst_ready = (buffer count > 0), combinationally from the registered count.
REQ-018 SHALL hold the head fields stable while i_inst_ack=0 and during the cycle i_inst_ack=1; it pops the head at the rising edge where i_inst_ack=1.
REQ-019 SHALL ignore i_inst_ack when o_inst_ready=0: no pop and no count underflow.
REQ-020 SHALL assert o_mem_rd in state RUN only when count + inflight < BUF_DEPTH, counting a pop in the same cycle toward free space.
REQ-021 SHALL drive o_mem_addr = PC while o_mem_rd=1 and increment PC by 1 on each issued read, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-022 SHALL push i_mem_data with its issuing address into the tail on the cycle after o_mem_rd, unless a flush occurred in between.
REQ-023 SHALL handle push and pop in the same cycle with the count unchanged and FIFO order preserved; read/write pointers wrap modulo BUF_DEPTH.
REQ-024 SHALL never overflow the buffer; a push into a full buffer is a design error, covered by an assertion.
REQ-025 SHALL use FSM states RUN and HALT; RUN moves to HALT when a pushed word has opcode 4'h0 (HLT), with no read issued in that cycle.
REQ-026 SHALL leave the HLT word and all earlier buffered words deliverable in HALT; o_halted=1 in HALT and o_mem_rd=0.
REQ-027 SHALL, on i_flush=1 at a rising edge, take priority over ack, push and issue: count, pointers and inflight cleared, the pending memory return discarded, PC set to i_flush_addr, state RUN.
REQ-028 SHALL hold o_mem_rd=0 in the flush cycle; the first read of i_flush_addr is issued the next cycle.
REQ-029 SHALL give first-instruction latency from reset release or flush: o_mem_rd at cycle 1, o_inst_ready=1 at cycle 2.
REQ-030 SHALL sustain one instruction per cycle with BUF_DEPTH>=2 and a consumer acking every cycle.

Reset
REQ-031 SHALL, while i_rst_n=0, set PC=0, count=0, inflight=0, pointers=0, state RUN, o_inst_ready=0, o_mem_rd=0, o_halted=0, o_mem_addr=0, and head fields and o_inst_pc to 0.
REQ-032 SHALL release reset synchronously internally, so the first o_mem_rd occurs on the first edge after the reset-release edge.
REQ-033 SHALL abort on reset mid-operation: in-flight data is discarded like a flush.

Verification
REQ-034 Reset release, memory[0..3]=F041,D042,B040,0000, ack every other cycle -> reads addr 0..3; consumer receives F,D,B,0 in order with o_inst_pc 0..3; o_halted=1 after addr 3 is pushed; no read of addr 4.
REQ-035 Consumer never acks -> exactly BUF_DEPTH reads issued; o_mem_rd stays 0; head stays F041 at pc 0.
REQ-036 Buffer full, ack and return in the same cycle -> count unchanged, next head correct, no lost word.
REQ-037 i_flush=1 with i_flush_addr=0x20 while a read is in flight and the buffer is full -> next cycle o_inst_ready=0 and stale data is not pushed; the read of 0x20 follows; first delivered o_inst_pc=0x20.
REQ-038 PC=0x3FF -> reads 0x3FF then 0x000; o_inst_pc follows the same order.
REQ-039 i_rst_n asserted asynchronously mid-cycle with the buffer non-empty -> o_inst_ready=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit port bundle: flush/redirect, instruction-memory read port and consumer handshake.
// master = fetch unit side, slave = memory/consumer side.
interface fetch_unit_if #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_flush;
  logic [ADDR_WIDTH-1:0] i_flush_addr;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_rd;
  logic [INST_WIDTH-1:0] i_mem_data;
  logic [3:0]            o_opcode;
  logic [5:0]            o_operand1;
  logic [5:0]            o_operand2;
  logic [ADDR_WIDTH-1:0] o_inst_pc;
  logic                  o_inst_ready;
  logic                  i_inst_ack;
  logic                  o_halted;

  modport master (
    input  i_flush, i_flush_addr, i_mem_data, i_inst_ack,
    output o_mem_addr, o_mem_rd, o_opcode, o_operand1, o_operand2,
           o_inst_pc, o_inst_ready, o_halted
  );

  modport slave (
    output i_flush, i_flush_addr, i_mem_data, i_inst_ack,
    input  o_mem_addr, o_mem_rd, o_opcode, o_operand1, o_operand2,
           o_inst_pc, o_inst_ready, o_halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with BUF_DEPTH-entry buffer: read issued 1 cycle after reset/flush, head valid the cycle after.
// Reads only issue when buffered + in-flight words fit (a same-cycle pop counts as free); stops fetching on HLT.
module fetch_unit #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int BUF_DEPTH  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = BUF_DEPTH[CW-1:0];
  localparam logic [CW:0]   DEPTH_L = BUF_DEPTH[CW:0];

  typedef enum logic {RUN, HALT} state_t;

  state_t                state;
  logic                  run_en;
  logic                  halted;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] pc;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [INST_WIDTH-1:0] inst_buf [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_buf   [BUF_DEPTH];

  logic                  do_pop;
  logic                  do_push;
  logic                  push_hlt;
  logic                  issue;
  logic [CW:0]           level;

  // rd_q marks the cycle in which the memory return is on i_mem_data
  always_comb begin
    do_pop   = bus.i_inst_ack && (count != '0);
    do_push  = rd_q;
    push_hlt = rd_q && (bus.i_mem_data[INST_WIDTH-1 -: 4] == 4'h0);
    level    = {1'b0, count} + {{CW{1'b0}}, rd_q} - {{CW{1'b0}}, do_pop};
    issue    = run_en && (state == RUN) && !bus.i_flush && !push_hlt && (level < DEPTH_L);
  end

  assign bus.o_mem_rd     = issue;
  assign bus.o_mem_addr   = pc;
  assign bus.o_inst_ready = (count != '0);
  assign bus.o_opcode     = inst_buf[rd_ptr][INST_WIDTH-1 -: 4];
  assign bus.o_operand1   = inst_buf[rd_ptr][INST_WIDTH-5 -: 6];
  assign bus.o_operand2   = inst_buf[rd_ptr][5:0];
  assign bus.o_inst_pc    = pc_buf[rd_ptr];
  assign bus.o_halted     = halted;

  // run_en delays fetching by one edge so reset release is seen synchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      halted    <= 1'b0;
      run_en    <= 1'b0;
      rd_q      <= 1'b0;
      rd_addr_q <= '0;
      pc        <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      run_en <= 1'b1;
      if (bus.i_flush) begin
        state  <= RUN;
        halted <= 1'b0;
        rd_q   <= 1'b0;
        pc     <= bus.i_flush_addr;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_q <= issue;
        if (issue) begin
          pc        <= pc + 1'b1;
          rd_addr_q <= pc;
        end
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(do_push) - CW'(do_pop);
        if ((state == RUN) && push_hlt) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_buf[i] <= '0;
        pc_buf[i]   <= '0;
      end
    end else if (do_push && !bus.i_flush) begin
      inst_buf[wr_ptr] <= bus.i_mem_data;
      pc_buf[wr_ptr]   <= rd_addr_q;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(do_push && !do_pop && !bus.i_flush && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences,
// and randomized ack/flush traffic against an instruction-stream reference model.
module tb_fetch_unit;
  localparam int IW = 16;
  localparam int AW = 10;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW)) bus();

  fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .BUF_DEPTH(BD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [IW-1:0] mem [1 << AW];
  always @(posedge clk) if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          ack;
    logic          rdy;
    logic          rd;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          halt;
  } vec_t;
  vec_t vt[12];

  // stream model: next expected delivered pc, next expected read address
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] nxt_fetch;
  bit            done;
  int            outstanding;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic fl, input logic [AW-1:0] fa, input logic ak);
    @(negedge clk);
    bus.i_flush      = fl;
    bus.i_flush_addr = fa;
    bus.i_inst_ack   = ak;
    #1;
  endtask

  task automatic head(input string nm, input logic [AW-1:0] pc, input logic [IW-1:0] inst);
    chk({nm, "_rdy"}, 32'(bus.o_inst_ready), 32'd1);
    chk({nm, "_pc"}, 32'(bus.o_inst_pc), 32'(pc));
    chk({nm, "_opcode"}, 32'(bus.o_opcode), 32'(inst[15:12]));
    chk({nm, "_op1"}, 32'(bus.o_operand1), 32'(inst[11:6]));
    chk({nm, "_op2"}, 32'(bus.o_operand2), 32'(inst[5:0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_flush_addr = '0;
    bus.i_inst_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", 32'(bus.o_inst_ready), 32'd0);
    chk("rst_rd", 32'(bus.o_mem_rd), 32'd0);
    chk("rst_halted", 32'(bus.o_halted), 32'd0);
    chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_pc", 32'(bus.o_inst_pc), 32'd0);
    chk("rst_fields", 32'({bus.o_opcode, bus.o_operand1, bus.o_operand2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rnd_cycle(input logic fl, input logic [AW-1:0] fa, input logic ak);
    logic [IW-1:0] w;
    step(fl, fa, ak);
    if (fl) begin
      chk("rnd_flush_rd", 32'(bus.o_mem_rd), 32'd0);
      exp_pc = fa;
      nxt_fetch = fa;
      done = 1'b0;
      outstanding = 0;
    end else begin
      if (done) begin
        chk("rnd_after_hlt_rdy", 32'(bus.o_inst_ready), 32'd0);
        chk("rnd_after_hlt_rd", 32'(bus.o_mem_rd), 32'd0);
      end
      if (bus.o_inst_ready && ak) begin
        w = mem[exp_pc];
        chk("rnd_pc", 32'(bus.o_inst_pc), 32'(exp_pc));
        chk("rnd_inst", 32'({bus.o_opcode, bus.o_operand1, bus.o_operand2}), 32'(w));
        if (w[15:12] == 4'h0) done = 1'b1;
        exp_pc = exp_pc + 1'b1;
        outstanding--;
      end
      if (bus.o_mem_rd) begin
        chk("rnd_rd_addr", 32'(bus.o_mem_addr), 32'(nxt_fetch));
        chk("rnd_rd_halted", 32'(bus.o_halted), 32'd0);
        nxt_fetch = nxt_fetch + 1'b1;
        outstanding++;
        chk("rnd_space", 32'(outstanding <= BD), 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] w;
    logic [AW-1:0] wpc [5];
    logic [IW-1:0] winst [5];
    int reads;

    // memory: random words, HLT at least every 16 words so every stream terminates
    for (int i = 0; i < (1 << AW); i++) begin
      w = 16'($urandom);
      if ((i % 16 == 15) || ($urandom_range(0, 9) == 0)) w[15:12] = 4'h0;
      else if (w[15:12] == 4'h0) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'hF041; mem[1] = 16'hD042; mem[2] = 16'hB040; mem[3] = 16'h0000;
    mem[10'h020] = 16'hA123;
    mem[10'h3FF] = 16'h1111;

    vt[0]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 10'h001, 10'h000, 16'h0000, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 10'h002, 10'h000, 16'hF041, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h001, 16'hD042, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 10'h003, 10'h001, 16'hD042, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h002, 16'hB040, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h002, 16'hB040, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h003, 16'h0000, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 10'h000, 10'h003, 16'h0000, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b1};

    // program F,D,B,HLT with ack every other cycle
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, vt[i].ack);
      chk($sformatf("v%0d_rdy", i), 32'(bus.o_inst_ready), 32'(vt[i].rdy));
      chk($sformatf("v%0d_rd", i), 32'(bus.o_mem_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d_halted", i), 32'(bus.o_halted), 32'(vt[i].halt));
      if (vt[i].rd) chk($sformatf("v%0d_addr", i), 32'(bus.o_mem_addr), 32'(vt[i].addr));
      if (vt[i].rdy) begin
        chk($sformatf("v%0d_pc", i), 32'(bus.o_inst_pc), 32'(vt[i].pc));
        chk($sformatf("v%0d_inst", i), 32'({bus.o_opcode, bus.o_operand1, bus.o_operand2}), 32'(vt[i].inst));
      end
    end

    // consumer stalls: buffer fills, then ack with return in flight
    do_reset();
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0);
      if (bus.o_mem_rd) reads++;
    end
    chk("noack_reads", 32'(reads), 32'(BD));
    chk("noack_rd", 32'(bus.o_mem_rd), 32'd0);
    head("noack_head", 10'h000, 16'hF041);
    step(1'b0, '0, 1'b1);
    head("full_ack0", 10'h000, 16'hF041);
    chk("full_ack0_rd", 32'(bus.o_mem_rd), 32'd1);
    chk("full_ack0_addr", 32'(bus.o_mem_addr), 32'h002);
    step(1'b0, '0, 1'b1);
    head("full_ack1", 10'h001, 16'hD042);
    chk("full_ack1_rd", 32'(bus.o_mem_rd), 32'd1);
    chk("full_ack1_addr", 32'(bus.o_mem_addr), 32'h003);
    step(1'b0, '0, 1'b0);
    head("full_ack2", 10'h002, 16'hB040);
    chk("full_ack2_rd", 32'(bus.o_mem_rd), 32'd0);
    step(1'b0, '0, 1'b0);
    head("full_ack3", 10'h002, 16'hB040);
    chk("full_ack3_halted", 32'(bus.o_halted), 32'd1);

    // flush with a read in flight, then async reset with buffer non-empty
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 10'h020, 1'b0);
    chk("flush_cyc_rd", 32'(bus.o_mem_rd), 32'd0);
    chk("flush_cyc_rdy", 32'(bus.o_inst_ready), 32'd1);
    step(1'b0, '0, 1'b0);
    chk("flush1_rdy", 32'(bus.o_inst_ready), 32'd0);
    chk("flush1_rd", 32'(bus.o_mem_rd), 32'd1);
    chk("flush1_addr", 32'(bus.o_mem_addr), 32'h020);
    step(1'b0, '0, 1'b0);
    chk("flush2_rdy", 32'(bus.o_inst_ready), 32'd0);
    chk("flush2_addr", 32'(bus.o_mem_addr), 32'h021);
    step(1'b0, '0, 1'b0);
    head("flush_head", 10'h020, 16'hA123);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(bus.o_inst_ready), 32'd0);
    chk("async_rst_rd", 32'(bus.o_mem_rd), 32'd0);

    // PC wrap 0x3FF -> 0x000 with ack every cycle (full throughput)
    do_reset();
    step(1'b1, 10'h3FF, 1'b1);
    chk("wrap_flush_rd", 32'(bus.o_mem_rd), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("wrap_rd0_addr", 32'(bus.o_mem_addr), 32'h3FF);
    chk("wrap_rd0", 32'(bus.o_mem_rd), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("wrap_rd1_addr", 32'(bus.o_mem_addr), 32'h000);
    chk("wrap_rd1", 32'(bus.o_mem_rd), 32'd1);
    wpc[0] = 10'h3FF; wpc[1] = 10'h000; wpc[2] = 10'h001; wpc[3] = 10'h002; wpc[4] = 10'h003;
    winst[0] = 16'h1111; winst[1] = 16'hF041; winst[2] = 16'hD042; winst[3] = 16'hB040; winst[4] = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1);
      head($sformatf("wrap_head%0d", k), wpc[k], winst[k]);
    end
    step(1'b0, '0, 1'b0);
    chk("wrap_end_rdy", 32'(bus.o_inst_ready), 32'd0);
    chk("wrap_end_halted", 32'(bus.o_halted), 32'd1);

    // randomized ack/flush traffic against the stream model
    do_reset();
    rnd_cycle(1'b1, AW'($urandom_range(0, (1 << AW) - 1)), 1'b0);
    for (int n = 0; n < 3000; n++) begin
      rnd_cycle(($urandom_range(0, 59) == 0), AW'($urandom_range(0, (1 << AW) - 1)),
                1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 300 && !done; n++) rnd_cycle(1'b0, '0, 1'b1);
    chk("drain_done", 32'(done), 32'd1);
    chk("drain_halted", 32'(bus.o_halted), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
